// File: rtl/wb_unit_pkg.sv
// rtl/wb_unit_pkg.sv - opcode/funct3 constants, writeback selects and FSM states for wb_unit
package wb_unit_pkg;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_IO_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    wb_sel_e wb_sel;
    logic    regwen;
  } dec_t;

  function automatic logic f_misalign(input logic [2:0] funct3, input logic [1:0] addr);
    case (funct3)
      F3_LH, F3_LHU: return addr[0];
      F3_LW:         return (addr != 2'b00);
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/wb_unit_load_extract.sv
// rtl/wb_unit_load_extract.sv - byte/half/word selection and sign/zero extension of a load word
module load_extract
  import wb_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_addr,
  input  logic [XLEN-1:0] i_word,
  output logic [XLEN-1:0] o_data,
  output logic            o_misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_addr)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half     = i_addr[1] ? i_word[31:16] : i_word[15:0];
    o_misalign = f_misalign(i_funct3, i_addr);
    case (i_funct3)
      F3_LB:   o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_LBU:  o_data = {{(XLEN-8){1'b0}}, w_byte};
      F3_LH:   o_data = {{(XLEN-16){w_half[15]}}, w_half};
      F3_LHU:  o_data = {{(XLEN-16){1'b0}}, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/wb_unit.sv
// rtl/wb_unit.sv - writeback stage: decode, load alignment, DMEM/IO load data and register-file write port
module wb_unit
  import wb_unit_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NUM_IO     = 2,
  parameter int IO_IDX_LSB = 4,
  parameter int IO_TIMEOUT = 255
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  input  logic [31:0]            i_in_inst,
  input  logic [XLEN-1:0]        i_in_alu,
  input  logic [XLEN-1:0]        i_in_pc4,
  input  logic [XLEN-1:0]        i_dmem_dout,
  output logic [NUM_IO-1:0]      o_io_req,
  input  logic [NUM_IO-1:0]      i_io_rvalid,
  input  logic [NUM_IO*XLEN-1:0] i_io_rdata,
  output logic                   o_rf_we,
  output logic [4:0]             o_rf_waddr,
  output logic [XLEN-1:0]        o_rf_wdata,
  output logic                   o_err_misalign,
  output logic                   o_err_timeout
);

  localparam int IDXW = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;
  localparam int CW   = $clog2(IO_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_VAL = CW'(IO_TIMEOUT);

  function automatic dec_t f_decode(input logic [4:0] opc);
    dec_t d;
    d.wb_sel = WB_ALU;
    d.regwen = 1'b0;
    case (opc)
      OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: begin d.wb_sel = WB_ALU; d.regwen = 1'b1; end
      OPC_JAL, OPC_JALR:                      begin d.wb_sel = WB_PC4; d.regwen = 1'b1; end
      OPC_LOAD:                               begin d.wb_sel = WB_MEM; d.regwen = 1'b1; end
      default: ;
    endcase
    return d;
  endfunction

  state_e            r_state;
  logic [CW-1:0]     r_cnt;
  logic [NUM_IO-1:0] r_io_req;
  logic              r_s1_valid;
  wb_sel_e           r_s1_wb_sel;
  logic [2:0]        r_s1_funct3;
  logic [1:0]        r_s1_addr;
  logic [4:0]        r_s1_rd;
  logic              r_s1_regwen;
  logic              r_s1_io;
  logic [IDXW-1:0]   r_s1_idx;
  logic [XLEN-1:0]   r_s1_alu;
  logic [XLEN-1:0]   r_s1_pc4;

  dec_t              w_dec;
  logic              w_accept, w_in_io, w_in_misalign, w_io_start;
  logic [IDXW-1:0]   w_in_idx;
  logic [NUM_IO-1:0] w_req_oh, w_idx_oh;
  logic [XLEN-1:0]   w_io_word, w_word, w_ld_data;
  logic              w_rvalid_sel, w_wait, w_io_done, w_timeout;
  logic              w_ext_mis, w_misalign, w_slot;
  logic              w_unused;

  assign w_dec         = f_decode(i_in_inst[6:2]);
  assign o_in_ready    = (r_state == ST_RUN);
  assign w_accept      = i_in_valid && o_in_ready;
  assign w_in_io       = i_in_alu[XLEN-1] && (w_dec.wb_sel == WB_MEM);
  assign w_in_misalign = f_misalign(i_in_inst[14:12], i_in_alu[1:0]);
  assign w_io_start    = w_accept && w_in_io && !w_in_misalign;
  assign w_unused      = ^{i_in_inst[31:15], i_in_inst[1:0]};

  generate
    if (NUM_IO > 1) begin : g_idx
      assign w_in_idx = i_in_alu[IO_IDX_LSB +: IDXW];
    end else begin : g_idx0
      assign w_in_idx = '0;
    end
  endgenerate

  // Indices past NUM_IO-1 match no source, so such a load can only time out.
  always_comb begin
    w_req_oh  = '0;
    w_idx_oh  = '0;
    w_io_word = '0;
    for (int i = 0; i < NUM_IO; i++) begin
      w_req_oh[i] = (w_in_idx == IDXW'(i));
      if (r_s1_idx == IDXW'(i)) begin
        w_idx_oh[i] = 1'b1;
        w_io_word   = i_io_rdata[i*XLEN +: XLEN];
      end
    end
  end

  assign w_rvalid_sel = |(i_io_rvalid & w_idx_oh);
  assign w_wait       = (r_state == ST_IO_WAIT);
  assign w_io_done    = w_wait && w_rvalid_sel;
  assign w_timeout    = w_wait && !w_rvalid_sel && (r_cnt == TO_VAL);
  assign w_word       = r_s1_io ? w_io_word : i_dmem_dout;

  load_extract #(.XLEN(XLEN)) u_load_extract (
    .i_funct3   (r_s1_funct3),
    .i_addr     (r_s1_addr),
    .i_word     (w_word),
    .o_data     (w_ld_data),
    .o_misalign (w_ext_mis)
  );

  assign w_misalign     = (r_s1_wb_sel == WB_MEM) && w_ext_mis;
  assign w_slot         = r_s1_valid && (!w_wait || w_io_done || w_timeout);
  assign o_rf_we        = w_slot && r_s1_regwen && (r_s1_rd != 5'd0) && !w_misalign;
  assign o_rf_waddr     = r_s1_rd;
  assign o_err_misalign = r_s1_valid && !w_wait && w_misalign;
  assign o_err_timeout  = w_timeout;
  assign o_io_req       = r_io_req;

  always_comb begin
    case (r_s1_wb_sel)
      WB_PC4:  o_rf_wdata = r_s1_pc4;
      WB_MEM:  o_rf_wdata = w_timeout ? '0 : w_ld_data;
      default: o_rf_wdata = r_s1_alu;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state     <= ST_RUN;
      r_cnt       <= '0;
      r_io_req    <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_wb_sel <= WB_ALU;
      r_s1_funct3 <= '0;
      r_s1_addr   <= '0;
      r_s1_rd     <= '0;
      r_s1_regwen <= 1'b0;
      r_s1_io     <= 1'b0;
      r_s1_idx    <= '0;
      r_s1_alu    <= '0;
      r_s1_pc4    <= '0;
    end else begin
      r_io_req <= '0;
      case (r_state)
        ST_RUN: begin
          r_s1_valid <= w_accept;
          if (w_accept) begin
            r_s1_wb_sel <= w_dec.wb_sel;
            r_s1_funct3 <= i_in_inst[14:12];
            r_s1_addr   <= i_in_alu[1:0];
            r_s1_rd     <= i_in_inst[11:7];
            r_s1_regwen <= w_dec.regwen;
            r_s1_io     <= w_in_io;
            r_s1_idx    <= w_in_idx;
            r_s1_alu    <= i_in_alu;
            r_s1_pc4    <= i_in_pc4;
          end
          if (w_io_start) begin
            r_state  <= ST_IO_WAIT;
            r_cnt    <= '0;
            r_io_req <= w_req_oh;
          end
        end
        ST_IO_WAIT: begin
          if (w_io_done || w_timeout) begin
            r_state    <= ST_RUN;
            r_s1_valid <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: doc/wb_unit.md
# wb_unit

Parametrised writeback stage for the RISC-V core: it accepts one retiring instruction per cycle from the memory stage, decodes its writeback source, and drives the register-file write port. Loads are aligned and sign/zero-extended from DMEM or from one of `NUM_IO` memory-mapped read sources with variable latency. Upstream is stalled while an IO read is outstanding. Undefined opcodes, misaligned loads and IO timeouts are handled explicitly, and every output is fully defined on every path.

## Interface
- `XLEN`, 32: datapath width.
- `NUM_IO`, 2: number of memory-mapped read sources (≥1).
- `IO_IDX_LSB`, 4: LSB of the IO index field in the load address; index = `addr[IO_IDX_LSB +: $clog2(NUM_IO)]`.
- `IO_TIMEOUT`, 255: IO_WAIT cycles before abort (≥1).

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-low reset.
- `in_valid` in 1: memory stage presents an instruction.
- `in_ready` out 1: instruction accepted on `in_valid && in_ready`.
- `in_inst` in 32: instruction word.
- `in_alu` in XLEN: ALU result, which is also the load address.
- `in_pc4` in XLEN: PC+4.
- `dmem_dout` in XLEN: DMEM read word, valid the cycle after acceptance.
- `io_req` out NUM_IO: one-cycle read strobe per source.
- `io_rvalid` in NUM_IO: per-source read-data valid.
- `io_rdata` in NUM_IO*XLEN: per-source read data, source i at `[i*XLEN +: XLEN]`.
- `rf_we` out 1: register-file write enable.
- `rf_waddr` out 5: destination register.
- `rf_wdata` out XLEN: write data.
- `err_misalign` out 1: one-cycle pulse for a misaligned load.
- `err_timeout` out 1: one-cycle pulse for an IO timeout.

## Operation
- Decode is based on `inst[6:2]`:
  - R-type, I-type ALU, LUI and AUIPC select ALU.
  - JAL and JALR select PC4.
  - Loads select MEM.
  - Store, branch and any other opcode set regwen=0.
- A load is an IO load when `addr[XLEN-1]`=1; otherwise it is a DMEM load.
- Stage register S1 captures the following on accept: valid, wb_sel, funct3, `addr[1:0]`, rd, regwen, io flag, io index, alu, pc4.
- `rf_we` = S1 valid && regwen && rd≠0 && not misaligned. A write to x0 never asserts `rf_we`.
- Load extract, keyed on funct3:
  - LB/LBU: byte `addr[1:0]`, sign- or zero-extended.
  - LH/LHU: half `addr[1]`, sign- or zero-extended.
  - LW: full word.
- Misalignment:
  - LH/LHU with `addr[0]`=1, or LW with `addr[1:0]`≠0, suppresses the write and pulses `err_misalign`.
  - A misaligned IO load issues no `io_req`.
- FSM has two states, RUN and IO_WAIT. Reset state is RUN.
  - In RUN, `in_ready`=1. Accepting an aligned IO load moves to IO_WAIT.
  - In IO_WAIT, `in_ready`=0. `io_req[idx]` is high on the first IO_WAIT cycle only.
  - In IO_WAIT, when `io_rvalid[idx]`=1 (sampled from the req cycle onward): write the extracted `io_rdata[idx]` that cycle, then return to RUN.
  - `io_rvalid` on other indices is ignored.
  - A timeout counter clears on entering IO_WAIT and increments each IO_WAIT cycle without rvalid. When it reaches `IO_TIMEOUT`: write 0 to rd (subject to rd≠0), pulse `err_timeout`, return to RUN.
- Reset values:
  - `rf_we`, `io_req`, `err_*` = 0.
  - `rf_waddr` and `rf_wdata` = 0.
  - S1 invalid, FSM in RUN, counter = 0.
  - Reset asserted mid-IO_WAIT aborts the load with no write.

## Timing
- Non-IO instructions: the write occurs the cycle after acceptance. Throughput is 1 instruction/cycle.
- DMEM load: `dmem_dout` is used combinationally in the write cycle.
- IO load: the write occurs at the earliest 1 cycle after acceptance (rvalid in the req cycle). `in_ready` rises the cycle after the write.
- `rf_wdata` and `rf_we` are combinational from S1 and the load-data mux. No output is registered beyond S1.
- `err_misalign` coincides with the suppressed write cycle.

## Structure
- Shared package holds:
  - opcode5 and funct3 constants (existing opcode header).
  - wb_sel encodings WB_ALU/WB_MEM/WB_PC4 (existing control-select header).
  - FSM state encoding.
- Sub-module `load_extract`: combinational; inputs funct3, `addr[1:0]`, word; outputs data and misalign.
- Decode is an in-module function with a full default assignment.

## Test plan
- ADDI x5 with alu=0x1234, then JAL x1 with pc4=0x0000_0104 back-to-back → `rf_we` on consecutive cycles, x5=0x1234 then x1=0x104.
- LB at addr 0x0000_0003 with dmem_dout=0x80FF_FFFF → x=0xFFFF_FF80. LBU same → 0x0000_0080. LH at addr 0x2 → 0xFFFF_80FF.
- LW at addr 0x8000_0010 (idx 1) with rvalid arriving 3 cycles after req, rdata=0xDEAD_BEEF → `in_ready` low 4 cycles, single write of 0xDEADBEEF. `io_rvalid[0]` pulses during the wait are ignored.
- IO load with no rvalid and `IO_TIMEOUT`=4 → `err_timeout` after 4 wait cycles, rd written 0, next instruction accepted the following cycle.
- LW at addr 0x2 → no write, `err_misalign` pulse. ADD to x0 → `rf_we`=0. SW and BEQ → `rf_we`=0. Opcode 0x7F → `rf_we`=0.
- `rst` driven low on the second IO_WAIT cycle → `io_req`, `rf_we` and `in_ready` behave as reset. A late rvalid causes no write.
